// File: rtl/sm83_intc.sv
// SM83 interrupt controller: edge-detected request flags (IF), an enable
// register (IE), a CPU-visible register window and a per-source irq vector.
// Arbitration between pending sources is left to the CPU.
module sm83_intc #(
    parameter int unsigned NUM_SRC = 5,
    parameter logic [15:0] IF_ADR  = 16'hFF0F,
    parameter logic [15:0] IE_ADR  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        adr,
    input  logic [7:0]         wdata,
    input  logic               rd,
    input  logic               wr,
    output logic [7:0]         rdata,
    output logic               rdata_oe,
    input  logic [NUM_SRC-1:0] src,
    output logic [7:0]         irq,
    input  logic [7:0]         iack,
    output logic [7:0]         dbg_if,
    output logic [7:0]         dbg_ie
);

    localparam int unsigned REG_W = 8;
    // Bits of an 8-bit register image that correspond to real sources.
    localparam logic [REG_W-1:0] IMPL_MASK = REG_W'((9'd1 << NUM_SRC) - 9'd1);

    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] if_q, if_d;
    logic [REG_W-1:0]   ie_q, ie_d;

    logic [NUM_SRC-1:0] rise;
    logic               hit_if, hit_ie;
    logic [REG_W-1:0]   if_pad;
    logic [REG_W-1:0]   if_rd;

    assign hit_if = (adr == IF_ADR);
    assign hit_ie = (adr == IE_ADR);
    assign rise   = src & ~src_q;

    // Register images: implemented IF bits zero-extended, unimplemented bits read as 1.
    assign if_pad = REG_W'(if_q);
    assign if_rd  = if_pad | ~IMPL_MASK;

    // Next-state: a rising edge beats an acknowledge, which beats a CPU write.
    always_comb begin
        src_d = src;
        if_d  = if_q;
        ie_d  = ie_q;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (rise[i]) begin
                if_d[i] = 1'b1;
            end else if (iack[i]) begin
                if_d[i] = 1'b0;
            end else if (wr && hit_if) begin
                if_d[i] = wdata[i];
            end
        end
        if (wr && hit_ie) begin
            ie_d = wdata;
        end
    end

    // State registers; src_q resets high so a level held through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= '1;
            if_q  <= '0;
            ie_q  <= '0;
        end else begin
            src_q <= src_d;
            if_q  <= if_d;
            ie_q  <= ie_d;
        end
    end

    // Requests to the CPU, purely from registered state.
    assign irq    = if_pad & ie_q & IMPL_MASK;
    assign dbg_if = if_pad;
    assign dbg_ie = ie_q;

    // Read mux: returns the pre-edge register contents for any decoded hit.
    always_comb begin
        rdata    = '0;
        rdata_oe = 1'b0;
        if (rd && hit_if) begin
            rdata    = if_rd;
            rdata_oe = 1'b1;
        end else if (rd && hit_ie) begin
            rdata    = ie_q;
            rdata_oe = 1'b1;
        end
    end

endmodule
